// File: rtl/sha256_stream_ctrl_pkg.sv
// Shared types and constants for the SHA-256 streaming front-end.
// Optional feature macro: SHA256_STREAM_CTRL_BLKCNT_EN (block pulse counter).
package sha256_stream_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StLen,
    StStart,
    StWait,
    StOut
  } state_e;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned LEN_HI_IDX  = 14;
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  // Keep the first n bytes (big-endian, byte0 in [31:24]) of a word.
  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    logic [31:0] mask;
    case (n)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'hff00_0000;
      3'd2:    mask = 32'hffff_0000;
      3'd3:    mask = 32'hffff_ff00;
      default: mask = 32'hffff_ffff;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational formatter for the final message word: masks unused bytes and
// drops the 0x80 terminator right after the last valid byte when it fits.
// Optional feature macro of the enclosing design: SHA256_STREAM_CTRL_BLKCNT_EN (unused here).
module sha256_pad_word
  import sha256_stream_ctrl_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o,
  output logic        marker_o,
  output logic [5:0]  bits_o
);

  logic [2:0] n;

  // Clamp byte count, mask the tail and place the terminator bit
  always_comb begin
    n        = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
    marker_o = (n < 3'd4);
    bits_o   = {n, 3'b000};
    word_o   = data_i & byte_mask(n);
    if (marker_o) begin
      word_o = word_o | (PAD_WORD >> {n, 3'b000});
    end
  end

endmodule

// File: rtl/sha256_stream_ctrl.sv
// Streaming front-end and sequencer for a SHA-256 core: assembles 512-bit
// blocks from 32-bit big-endian words, applies padding and the 64-bit length,
// drives core init/next and returns the digest over a valid/ready port.
// Optional feature macro: SHA256_STREAM_CTRL_BLKCNT_EN adds blk_count[31:0].
module sha256_stream_ctrl
  import sha256_stream_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [2:0]   s_nbytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_digest,
  input  logic         core_digest_valid,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [255:0] m_digest
`ifdef SHA256_STREAM_CTRL_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  state_e             state_q;
  logic [3:0]         wptr_q;
  logic               first_q;
  logic               marker_q;
  logic               final_q;
  logic               done_q;       // last message word already taken
  logic               wait_hold_q;  // first WAIT cycle, core_ready not yet meaningful
  logic [LEN_W-1:0]   bitlen_q;
  logic [31:0]        blk_q [BLOCK_WORDS];
  logic               s_ready_q;
  logic               core_init_q;
  logic               core_next_q;
  logic               m_valid_q;
  logic [255:0]       m_digest_q;

  logic [31:0]        pad_word;
  logic               pad_marker;
  logic [5:0]         pad_bits;
  logic [63:0]        len64;
  logic               accept;

  // Completion is taken from core_ready alone.
  logic unused_digest_valid;
  assign unused_digest_valid = core_digest_valid;

  sha256_pad_word u_pad_word (
    .data_i   (s_data),
    .nbytes_i (s_nbytes),
    .word_o   (pad_word),
    .marker_o (pad_marker),
    .bits_o   (pad_bits)
  );

  assign len64     = 64'(bitlen_q);
  assign accept    = s_valid && s_ready_q;
  assign s_ready   = s_ready_q;
  assign core_init = core_init_q;
  assign core_next = core_next_q;
  assign m_valid   = m_valid_q;
  assign m_digest  = m_digest_q;

  // Flatten the block buffer, word0 at the top
  always_comb begin
    core_block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      core_block[511 - 32*i -: 32] = blk_q[i];
    end
  end

  // Sequencer: message fill, padding, length, core handshake and digest output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      first_q     <= 1'b1;
      marker_q    <= 1'b0;
      final_q     <= 1'b0;
      done_q      <= 1'b0;
      wait_hold_q <= 1'b0;
      bitlen_q    <= '0;
      s_ready_q   <= 1'b0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_digest_q  <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        blk_q[i] <= '0;
      end
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (core_ready) begin
            state_q   <= StFill;
            s_ready_q <= 1'b1;
          end
        end

        StFill: begin
          if (accept) begin
            wptr_q <= wptr_q + 4'd1;
            if (s_last) begin
              blk_q[wptr_q] <= pad_word;
              bitlen_q      <= bitlen_q + LEN_W'(pad_bits);
              marker_q      <= pad_marker;
              done_q        <= 1'b1;
              s_ready_q     <= 1'b0;
              if (wptr_q == 4'(BLOCK_WORDS - 1)) begin
                state_q <= StStart;
                final_q <= 1'b0;
              end else if (pad_marker && wptr_q == 4'(LEN_HI_IDX - 1)) begin
                // Terminator landed just before the length slot
                state_q <= StLen;
              end else begin
                state_q <= StPad;
              end
            end else begin
              blk_q[wptr_q] <= s_data;
              bitlen_q      <= bitlen_q + LEN_W'(32);
              if (wptr_q == 4'(BLOCK_WORDS - 1)) begin
                s_ready_q <= 1'b0;
                state_q   <= StStart;
                final_q   <= 1'b0;
              end
            end
          end
        end

        StPad: begin
          blk_q[wptr_q] <= marker_q ? 32'h0 : PAD_WORD;
          marker_q      <= 1'b1;
          wptr_q        <= wptr_q + 4'd1;
          if (wptr_q == 4'(LEN_HI_IDX - 1)) begin
            state_q <= StLen;
          end else if (wptr_q == 4'(BLOCK_WORDS - 1)) begin
            // No room for the length: it goes in an extra block
            state_q <= StStart;
            final_q <= 1'b0;
          end
        end

        StLen: begin
          wptr_q <= wptr_q + 4'd1;
          if (wptr_q == 4'(LEN_HI_IDX)) begin
            blk_q[wptr_q] <= len64[63:32];
          end else begin
            blk_q[wptr_q] <= len64[31:0];
            state_q       <= StStart;
            final_q       <= 1'b1;
          end
        end

        StStart: begin
          core_init_q <= first_q;
          core_next_q <= !first_q;
          first_q     <= 1'b0;
          wptr_q      <= '0;
          wait_hold_q <= 1'b1;
          state_q     <= StWait;
        end

        StWait: begin
          if (wait_hold_q) begin
            wait_hold_q <= 1'b0;
          end else if (core_ready) begin
            if (final_q) begin
              m_digest_q <= core_digest;
              m_valid_q  <= 1'b1;
              state_q    <= StOut;
            end else if (done_q) begin
              state_q <= StPad;
            end else begin
              state_q   <= StFill;
              s_ready_q <= 1'b1;
            end
          end
        end

        StOut: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            bitlen_q  <= '0;
            first_q   <= 1'b1;
            marker_q  <= 1'b0;
            final_q   <= 1'b0;
            done_q    <= 1'b0;
            wptr_q    <= '0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SHA256_STREAM_CTRL_BLKCNT_EN
  logic [31:0] blk_count_q;

  // Count every block handed to the core
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_count_q <= '0;
    end else if (core_init_q || core_next_q) begin
      blk_count_q <= blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Self-checking bench for sha256_stream_ctrl with a behavioural SHA-256 core.
// Optional feature macro: SHA256_STREAM_CTRL_BLKCNT_EN (connects blk_count).
module tb_sha256_stream_ctrl;

  localparam int CORE_LAT = 10;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic [2:0]   s_nbytes;
  logic         core_init, core_next, core_ready, core_digest_valid;
  logic [511:0] core_block;
  logic [255:0] core_digest, m_digest;
  logic         m_valid, m_ready;
`ifdef SHA256_STREAM_CTRL_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  always #5 clk = ~clk;

  sha256_stream_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .s_nbytes          (s_nbytes),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_digest          (m_digest)
`ifdef SHA256_STREAM_CTRL_BLKCNT_EN
    ,
    .blk_count         (blk_count)
`endif
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural core: samples block on init/next, busy for CORE_LAT cycles
  int           busy_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready        <= 1'b1;
      core_digest_valid <= 1'b0;
      core_digest       <= '0;
      busy_q            <= 0;
    end else if (busy_q > 0) begin
      busy_q <= busy_q - 1;
      if (busy_q == 1) begin
        core_ready        <= 1'b1;
        core_digest_valid <= 1'b1;
      end
    end else if (core_init || core_next) begin
      core_digest       <= compress(core_init ? IV : core_digest, core_block);
      core_ready        <= 1'b0;
      core_digest_valid <= 1'b0;
      busy_q            <= CORE_LAT;
    end
  end

  int           init_cnt = 0;
  int           next_cnt = 0;
  logic [511:0] blk_log [$];
  always @(posedge clk) begin
    if (core_init) init_cnt <= init_cnt + 1;
    if (core_next) next_cnt <= next_cnt + 1;
    if (core_init || core_next) blk_log.push_back(core_block);
  end

  int            checks = 0;
  int            failures = 0;
  byte unsigned  msg_q [$];
  logic [255:0]  exp_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent software SHA-256 over msg_q
  function automatic logic [255:0] sw_sha();
    byte unsigned p [$];
    logic [63:0]  bl;
    logic [255:0] h;
    logic [511:0] blk;
    p = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      h = compress(h, blk);
    end
    return h;
  endfunction

  task automatic build_msg(input string text, input bit pattern, input int len);
    msg_q.delete();
    if (pattern) begin
      for (int i = 0; i < len; i++) msg_q.push_back(8'((i * 37 + 11) & 255));
    end else begin
      for (int i = 0; i < text.len(); i++) msg_q.push_back(text[i]);
    end
  endtask

  // Drive msg_q as words; bytes past the end carry junk to exercise masking
  task automatic send_msg();
    int          len, nw, n, cnt;
    logic [31:0] word;
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        word[31 - 8*k -: 8] = (4*w + k < len) ? msg_q[4*w + k] : 8'ha5;
      end
      n = (w == nw - 1) ? len - 4*w : 4;
      s_valid  = 1'b1;
      s_data   = word;
      s_last   = (w == nw - 1);
      s_nbytes = 3'(n);
      cnt = 0;
      while (!s_ready && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      if (!s_ready) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=s_ready_low required=s_ready_high word=%0d", w);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for a digest, hold back-pressure, then consume and compare with scoreboard
  task automatic recv(input string name, input int hold);
    int           cnt;
    logic [255:0] exp;
    cnt = 0;
    while (!m_valid && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (!m_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=m_valid_low required=m_valid_high", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 256'(m_valid), 256'd1);
      check({name, "_hold_digest"}, m_digest, exp);
      check({name, "_hold_sready"}, 256'(s_ready), 256'd0);
    end
    check({name, "_digest"}, m_digest, exp);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({name, "_valid_drop"}, 256'(m_valid), 256'd0);
  endtask

  typedef struct {
    string        text;
    bit           pattern;
    int           len;
    bit           have_exp;
    logic [255:0] exp;
    int           blocks;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int i0, n0, cnt;
    vecs[0]  = '{"abc", 1'b0, 0, 1'b1, DIG_ABC, 1};
    vecs[1]  = '{"", 1'b0, 0, 1'b1,
                 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1};
    vecs[2]  = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 1'b0, 0, 1'b1,
                 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 2};
    vecs[3]  = '{"", 1'b1, 55, 1'b0, '0, 1};
    vecs[4]  = '{"", 1'b1, 64, 1'b0, '0, 2};
    vecs[5]  = '{"", 1'b1, 1, 1'b0, '0, 1};
    vecs[6]  = '{"", 1'b1, 4, 1'b0, '0, 1};
    vecs[7]  = '{"", 1'b1, 52, 1'b0, '0, 1};
    vecs[8]  = '{"", 1'b1, 63, 1'b0, '0, 2};
    vecs[9]  = '{"", 1'b1, 119, 1'b0, '0, 2};
    vecs[10] = '{"", 1'b1, 120, 1'b0, '0, 3};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 256'(s_ready), 256'd0);
    check("rst_core_init", 256'(core_init), 256'd0);
    check("rst_core_next", 256'(core_next), 256'd0);
    check512("rst_core_block", core_block, 512'd0);
    check("rst_m_valid", 256'(m_valid), 256'd0);
    check("rst_m_digest", m_digest, 256'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      build_msg(vecs[v].text, vecs[v].pattern, vecs[v].len);
      exp_q.push_back(vecs[v].have_exp ? vecs[v].exp : sw_sha());
      i0 = init_cnt;
      n0 = next_cnt;
      send_msg();
      recv($sformatf("vec%0d", v), 0);
      check($sformatf("vec%0d_inits", v), 256'(init_cnt - i0), 256'd1);
      check($sformatf("vec%0d_nexts", v), 256'(next_cnt - n0), 256'(vecs[v].blocks - 1));
      if (v == 0)
        check512("abc_block", blk_log[blk_log.size() - 1],
                 {32'h61626380, 416'd0, 64'h18});
      if (v == 2)
        check512("b56_second_block", blk_log[blk_log.size() - 1], {448'd0, 64'h1c0});
      if (v == 4) begin
        check("b64_second_word0", 256'(blk_log[blk_log.size() - 1][511:480]),
              256'h8000_0000);
        check("b64_second_len", 256'(blk_log[blk_log.size() - 1][63:0]), 256'h200);
      end
    end

    // Back-pressure on the digest, then a second identical message
    build_msg("abc", 1'b0, 0);
    exp_q.push_back(DIG_ABC);
    send_msg();
    recv("abc_hold", 20);
    exp_q.push_back(DIG_ABC);
    send_msg();
    recv("abc_again", 0);

    // Reset while waiting on the first block of a two-block message
    build_msg("", 1'b1, 64);
    i0 = init_cnt;
    send_msg();
    cnt = 0;
    while (init_cnt == i0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_reset_reached_wait", 256'(init_cnt - i0), 256'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_s_ready", 256'(s_ready), 256'd0);
    check("arst_core_init", 256'(core_init), 256'd0);
    check("arst_core_next", 256'(core_next), 256'd0);
    check512("arst_core_block", core_block, 512'd0);
    check("arst_m_valid", 256'(m_valid), 256'd0);
    check("arst_m_digest", m_digest, 256'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    build_msg("abc", 1'b0, 0);
    exp_q.push_back(DIG_ABC);
    i0 = init_cnt;
    n0 = next_cnt;
    send_msg();
    recv("abc_after_reset", 0);
    check("abc_after_reset_inits", 256'(init_cnt - i0), 256'd1);
    check("abc_after_reset_nexts", 256'(next_cnt - n0), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_stream_ctrl.md
Name: sha256_stream_ctrl

Overview:
Streaming front-end and sequencer for the SHA-256 core. It accepts a message as 32-bit big-endian words over a valid/ready handshake and assembles 512-bit blocks. It applies FIPS 180-4 padding and the 64-bit length field, then pulses the core's init (first block) or next (later blocks) and waits for completion. The final digest is presented on a valid/ready output. It sits between a DMA/stream source and the core's init/next/block/ready/digest/digest_valid ports.

Parameters:
LEN_W, 64, width of the internal bit-length counter (32..64); zero-extended into the 64-bit length field; wraps mod 2^LEN_W.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset (clears all state immediately)
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  32  message word, byte0 in [31:24]
s_last  in  1  final word of message
s_nbytes  in  3  valid bytes in last word, 0..4 (only sampled with s_last; 5..7 treated as 4; non-last words are always 4 bytes)
core_init  out  1  one-cycle pulse, first block
core_next  out  1  one-cycle pulse, subsequent blocks
core_block  out  512  assembled block, word0 in [511:480]
core_ready  in  1  core idle
core_digest  in  256  core digest
core_digest_valid  in  1  core digest valid
m_valid  out  1  digest available
m_ready  in  1  digest consumed when m_valid&m_ready
m_digest  out  256  registered digest

Behaviour:
- Reset values: s_ready=0, core_init=0, core_next=0, core_block=0, m_valid=0, m_digest=0; state=IDLE, wptr=0, first=1, bitlen=0, marker=0.
- States: IDLE, FILL, PAD, LEN, START, WAIT, OUT.
- IDLE: when core_ready=1, go to FILL (s_ready=1 from the next cycle).
- FILL: s_ready=1 and one word is accepted per cycle into blk[wptr], then wptr++.
  - Non-last word: bitlen += 32.
  - Last word: bitlen += 8*n. Bytes >= n are zeroed. If n<4, 0x80 is placed at byte n and marker=1.
  - Ptr wrap: a data word at wptr=15 leads to START (final=0). wptr returns to 0 after the block, and FILL resumes if the message is not done.
- After the last word goes to PAD, s_ready=0.
- PAD: one word per cycle.
  - If marker=0, write 0x80000000 and set marker=1; otherwise write 0.
  - If marker=1 and wptr==14, go to LEN.
  - If wptr reaches 15 without room for the length, write 0 and go to START with final=0. The next block is all-zero padding: PAD from wptr=0, marker already set.
- Boundary: message bytes mod 64 <= 55 uses one pad block; 56..63 uses two.
- LEN: two cycles, writing blk[14]=len[63:32] and blk[15]=len[31:0]. Then START with final=1.
- START: one cycle. core_block is already stable and held from here until WAIT exits.
  - Assert core_init if first=1, else core_next. Then first=0.
- WAIT: the cycle right after the pulse ignores core_ready. Afterwards, exit on core_ready=1.
  - final=0: go to FILL, or to PAD if the last word has already been taken.
  - final=1: latch core_digest into m_digest, set m_valid=1, go to OUT.
- OUT: hold m_valid/m_digest until m_ready. Then m_valid=0, reset bitlen/first/marker/wptr, go to IDLE.
  - s_ready=0 throughout OUT, so the next message is back-pressured.
- Empty message (s_last with n=0): 0x80000000 is written at wptr 0, giving a single block with len=0.
- core_digest_valid is informational only; completion is determined by core_ready.
- Reset asserted mid-operation aborts the message and returns to the reset values asynchronously. The integrator must also reset the core (core reset_n = ~reset).
- Latency: "abc" gives m_valid = 16 + 1 + core compute cycles after the last word accepted.

Optional Feature:
Macro SHA256_STREAM_CTRL_BLKCNT_EN.
- Defined: adds output blk_count[31:0]. It increments on every core_init/core_next pulse, clears on reset only, and wraps at 2^32.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sha256_stream_ctrl_pkg holds:
  - the state enum;
  - constants BLOCK_WORDS=16, LEN_HI_IDX=14, PAD_WORD=32'h80000000;
  - function byte_mask(n).
- Sub-module sha256_pad_word: combinational, (s_data, n) -> padded last word plus marker_placed flag.

Test Plan:
- "abc" (word 0x61626300, s_last, n=3) -> m_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; exactly one core_init, no core_next.
- Empty (s_last, n=0) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; one core_init.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; one init plus one next, and the second block is zeros with len=0x1c0.
- 55-byte message -> single block (no core_next); 64-byte message -> two blocks, second block begins 0x80000000.
- Hold m_ready=0 for 20 cycles after "abc" -> m_valid and m_digest are stable and s_ready=0; then m_ready=1 for one cycle -> a second "abc" gives the same digest.
- Assert reset during WAIT of a two-block message -> all outputs return to reset values the same cycle; a subsequent "abc" is correct.
